ikaopll_cyclegen: RTL and testbench
===================================

IKAOPLL_CYCLEGEN -- requirements
Module: ikaopll_cyclegen

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, phiM enables per phi1 period; legal range even values 4..16.
REQ-002 SHALL have parameter CHANNELS, default 9, channels per frame; legal range 2..16.
REQ-003 SHALL have parameter RHYTHM_CHANNELS, default 3, trailing channels reusable as rhythm; legal range 0..CHANNELS.
REQ-004 SHALL define CW = clog2(2*CHANNELS) and HW = clog2(CHANNELS).
REQ-005 i_EMUCLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_RST  in  1  reset, synchronous, active-high.
REQ-007 i_phiM_PCEN_n  in  1  phiM positive-edge clock enable, active-low.
REQ-008 i_RHYTHM_EN  in  1  rhythm mode request.
REQ-009 o_phi1_PCEN_n / o_phi1_NCEN_n  out  1 each  phi1 positive/negative edge enables, active-low.
REQ-010 o_DAC_EN  out  1  DAC load enable, active-high.
REQ-011 o_CYCLE  out  CW  current operator cycle, 0..2*CHANNELS-1.
REQ-012 o_CH  out  HW  current channel, o_CYCLE>>1.
REQ-013 o_MnC_SEL  out  1  0 = modulator cycle, 1 = carrier cycle.
REQ-014 o_RHYTHM_CTRL  out  1  current channel is rhythm in the active frame.
REQ-015 o_CYCLE_00 / o_CYCLE_LAST  out  1 each  o_CYCLE==0 / o_CYCLE==2*CHANNELS-1.
REQ-016 o_MO_SAMPLE / o_RO_SAMPLE / o_FRAME  out  1 each  melody sample, rhythm sample, frame-wrap strobes.

Function
REQ-017 Prescaler p (0..PRESCALE-1) SHALL increment, wrapping to 0, on every i_EMUCLK edge with i_phiM_PCEN_n==0; otherwise hold.
REQ-018 o_phi1_NCEN_n SHALL be 0 exactly when p==0 and i_phiM_PCEN_n==0 (combinational, zero latency); o_DAC_EN SHALL equal its inverse.
REQ-019 o_phi1_PCEN_n SHALL be 0 exactly when p==PRESCALE/2 and i_phiM_PCEN_n==0.
REQ-020 Cycle counter c SHALL advance on each phi1 positive event (REQ-019 condition), wrapping 2*CHANNELS-1 -> 0; o_CYCLE=c registered, no further latency.
REQ-021 o_MnC_SEL SHALL equal c[0].
REQ-022 Registered rhythm_q SHALL sample i_RHYTHM_EN only on the wrap edge; changes mid-frame take effect at the next frame start.
REQ-023 o_RHYTHM_CTRL SHALL be 1 when rhythm_q==1 and o_CH >= CHANNELS-RHYTHM_CHANNELS; constant 0 when RHYTHM_CHANNELS==0.
REQ-024 o_MO_SAMPLE SHALL pulse one i_EMUCLK cycle, coincident with the phi1 positive event leaving a carrier cycle of a non-rhythm channel.
REQ-025 o_RO_SAMPLE SHALL pulse likewise for a carrier cycle of a rhythm channel; MO and RO never both 1.
REQ-026 o_FRAME SHALL pulse coincident with the wrap event (leaving c==2*CHANNELS-1).
REQ-027 With i_phiM_PCEN_n held 1 all state SHALL hold and all enables/strobes SHALL be inactive.

Reset
REQ-028 While i_RST==1 at an edge: p=0, c=0, rhythm_q=0.
REQ-029 While i_RST==1, o_phi1_PCEN_n=1, o_phi1_NCEN_n=1, o_DAC_EN=0, all strobes 0, regardless of i_phiM_PCEN_n.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no o_FRAME pulse; first cycle after release counts from p=0, c=0.

Structure
REQ-031 Parameter legality checks, CW/HW derivation function and role encodings (modulator/carrier) SHALL reside in the shared ikaopll package.
REQ-032 The prescaler SHALL be a sub-module ikaopll_prescaler (p counter plus enable decode); cycle, rhythm and strobe logic stay in ikaopll_cyclegen.

Verification
REQ-033 Defaults, i_phiM_PCEN_n=0 continuous: NCEN_n low at clocks 0,4,8...; PCEN_n low at 2,6,10...; o_CYCLE 0->1 at clock 2, wrap 17->0 after 72 clocks with o_FRAME=1.
REQ-034 i_phiM_PCEN_n active every other clock: phi1 period 8 clocks, frame 144 clocks; hold stretches everything, no extra strobes.
REQ-035 i_RHYTHM_EN=1 raised at o_CYCLE=5: frame 0 gives 9 MO_SAMPLE, 0 RO; next frame gives 6 MO (channels 0..5) and 3 RO (channels 6..8).
REQ-036 i_RST pulse at o_CYCLE=11: outputs inactive during reset, no o_FRAME; after release o_CYCLE=0, o_CYCLE_00=1, rhythm_q=0.
REQ-037 PRESCALE=8, CHANNELS=6, RHYTHM_CHANNELS=0: CW=4, o_CYCLE wraps 11->0 every 96 clocks, o_RO_SAMPLE never 1, o_RHYTHM_CTRL constant 0.

Source files
------------

// File: rtl/ikaopll_pkg.sv
// Shared definitions for the IKAOPLL timing blocks: operator roles,
// width derivation and parameter legality.
package ikaopll_pkg;

    typedef enum logic {
        ROLE_MOD = 1'b0,
        ROLE_CAR = 1'b1
    } role_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int cyc_width(input int channels);
        return clog2(2 * channels);
    endfunction

    function automatic int ch_width(input int channels);
        return clog2(channels);
    endfunction

    function automatic bit params_ok(input int prescale, input int channels, input int rhythm_channels);
        return (prescale >= 4) && (prescale <= 16) && (prescale % 2 == 0) &&
               (channels >= 2) && (channels <= 16) &&
               (rhythm_channels >= 0) && (rhythm_channels <= channels);
    endfunction

endpackage

// File: rtl/ikaopll_prescaler.sv
// Divides the phiM enable stream into phi1 positive/negative edge enables.
module ikaopll_prescaler
    import ikaopll_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic i_EMUCLK,
    input  logic i_RST,
    input  logic i_phiM_PCEN_n,
    output logic o_phi1_PCEN_n,
    output logic o_phi1_NCEN_n
);

    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_HALF = PW'(PRESCALE / 2);

    logic [PW-1:0] p_q, p_d;
    logic          en;

    // Reset masks the enable so no phi1 event can leak out while held.
    always_comb begin
        en  = ~i_phiM_PCEN_n & ~i_RST;
        p_d = p_q;
        if (en) p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) p_q <= '0;
        else       p_q <= p_d;
    end

    assign o_phi1_NCEN_n = ~(en && (p_q == '0));
    assign o_phi1_PCEN_n = ~(en && (p_q == P_HALF));

endmodule

// File: rtl/ikaopll_cyclegen.sv
// Operator cycle sequencer: walks modulator/carrier slots per channel and
// emits melody/rhythm sample strobes and the frame-wrap strobe.
module ikaopll_cyclegen
    import ikaopll_pkg::*;
#(
    parameter  int PRESCALE        = 4,
    parameter  int CHANNELS        = 9,
    parameter  int RHYTHM_CHANNELS = 3,
    localparam int CW              = cyc_width(CHANNELS),
    localparam int HW              = ch_width(CHANNELS)
) (
    input  logic          i_EMUCLK,
    input  logic          i_RST,
    input  logic          i_phiM_PCEN_n,
    input  logic          i_RHYTHM_EN,
    output logic          o_phi1_PCEN_n,
    output logic          o_phi1_NCEN_n,
    output logic          o_DAC_EN,
    output logic [CW-1:0] o_CYCLE,
    output logic [HW-1:0] o_CH,
    output logic          o_MnC_SEL,
    output logic          o_RHYTHM_CTRL,
    output logic          o_CYCLE_00,
    output logic          o_CYCLE_LAST,
    output logic          o_MO_SAMPLE,
    output logic          o_RO_SAMPLE,
    output logic          o_FRAME
);

    if (!params_ok(PRESCALE, CHANNELS, RHYTHM_CHANNELS)) begin : g_bad_params
        $error("ikaopll_cyclegen: illegal PRESCALE/CHANNELS/RHYTHM_CHANNELS");
    end

    localparam logic [CW-1:0] C_LAST  = CW'(2 * CHANNELS - 1);
    // One extra bit so CHANNELS itself is representable when no rhythm slots exist.
    localparam logic [HW:0]   R_FIRST = (HW + 1)'(CHANNELS - RHYTHM_CHANNELS);

    logic          phi1_pos;
    logic [CW-1:0] c_q, c_d;
    logic          rhythm_q, rhythm_d;
    logic          carrier, last, rhythm_ch;

    ikaopll_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .i_EMUCLK     (i_EMUCLK),
        .i_RST        (i_RST),
        .i_phiM_PCEN_n(i_phiM_PCEN_n),
        .o_phi1_PCEN_n(o_phi1_PCEN_n),
        .o_phi1_NCEN_n(o_phi1_NCEN_n)
    );

    assign phi1_pos  = ~o_phi1_PCEN_n;
    assign last      = (c_q == C_LAST);
    assign carrier   = (role_e'(c_q[0]) == ROLE_CAR);
    assign rhythm_ch = (RHYTHM_CHANNELS != 0) && rhythm_q && ({1'b0, o_CH} >= R_FIRST);

    // Rhythm mode is latched only at the wrap so a frame never mixes modes.
    always_comb begin
        c_d      = c_q;
        rhythm_d = rhythm_q;
        if (phi1_pos) begin
            c_d = last ? '0 : c_q + 1'b1;
            if (last) rhythm_d = i_RHYTHM_EN;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            c_q      <= '0;
            rhythm_q <= 1'b0;
        end else begin
            c_q      <= c_d;
            rhythm_q <= rhythm_d;
        end
    end

    assign o_DAC_EN      = ~o_phi1_NCEN_n;
    assign o_CYCLE       = c_q;
    assign o_CH          = c_q[CW-1:1];
    assign o_MnC_SEL     = c_q[0];
    assign o_RHYTHM_CTRL = rhythm_ch;
    assign o_CYCLE_00    = (c_q == '0);
    assign o_CYCLE_LAST  = last;
    assign o_MO_SAMPLE   = phi1_pos & carrier & ~rhythm_ch;
    assign o_RO_SAMPLE   = phi1_pos & carrier & rhythm_ch;
    assign o_FRAME       = phi1_pos & last;

endmodule

// File: tb/tb_ikaopll_cyclegen.sv
// Bench for ikaopll_cyclegen: default build plus a PRESCALE=8/6-channel build.
module tb_ikaopll_cyclegen;

    typedef struct {
        int kind;  // 0 = MO, 1 = RO, 2 = FRAME
        int ch;
    } ev_t;

    logic clk;
    logic rst, phim_n, rhy_en;
    logic pcen_n, ncen_n, dac, mnc, rctl, c00, clast, mo, ro, frm;
    logic [4:0] cyc;
    logic [3:0] ch;

    logic rst2, phim2_n, rhy2;
    logic pcen2_n, ncen2_n, dac2, mnc2, rctl2, c002, clast2, mo2, ro2, frm2;
    logic [3:0] cyc2;
    logic [2:0] ch2;

    int  total, bad;
    ev_t exp_q[$];
    ev_t exp2_q[$];
    ev_t e1, e2;
    bit  mon1, mon2;

    ikaopll_cyclegen u_dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(phim_n), .i_RHYTHM_EN(rhy_en),
        .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n), .o_DAC_EN(dac),
        .o_CYCLE(cyc), .o_CH(ch), .o_MnC_SEL(mnc), .o_RHYTHM_CTRL(rctl),
        .o_CYCLE_00(c00), .o_CYCLE_LAST(clast),
        .o_MO_SAMPLE(mo), .o_RO_SAMPLE(ro), .o_FRAME(frm)
    );

    ikaopll_cyclegen #(.PRESCALE(8), .CHANNELS(6), .RHYTHM_CHANNELS(0)) u_dut2 (
        .i_EMUCLK(clk), .i_RST(rst2), .i_phiM_PCEN_n(phim2_n), .i_RHYTHM_EN(rhy2),
        .o_phi1_PCEN_n(pcen2_n), .o_phi1_NCEN_n(ncen2_n), .o_DAC_EN(dac2),
        .o_CYCLE(cyc2), .o_CH(ch2), .o_MnC_SEL(mnc2), .o_RHYTHM_CTRL(rctl2),
        .o_CYCLE_00(c002), .o_CYCLE_LAST(clast2),
        .o_MO_SAMPLE(mo2), .o_RO_SAMPLE(ro2), .o_FRAME(frm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every strobe the DUT raises must match the next expected event.
    always @(negedge clk) begin
        if (mon1) begin
            for (int s = 0; s < 3; s++) begin
                if ((s == 0 && mo) || (s == 1 && ro) || (s == 2 && frm)) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb1_unexpected got kind=%0d ch=%0d t=%0t, expected no event", s, ch, $time);
                    end else begin
                        e1 = exp_q.pop_front();
                        if (e1.kind != s || (s != 2 && e1.ch != int'(ch))) begin
                            bad++;
                            $display("FAIL sb1_event got kind=%0d ch=%0d expected kind=%0d ch=%0d t=%0t",
                                     s, ch, e1.kind, e1.ch, $time);
                        end
                    end
                end
            end
        end
        if (mon2) begin
            for (int s = 0; s < 3; s++) begin
                if ((s == 0 && mo2) || (s == 1 && ro2) || (s == 2 && frm2)) begin
                    total++;
                    if (exp2_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb2_unexpected got kind=%0d ch=%0d t=%0t, expected no event", s, ch2, $time);
                    end else begin
                        e2 = exp2_q.pop_front();
                        if (e2.kind != s || (s != 2 && e2.ch != int'(ch2))) begin
                            bad++;
                            $display("FAIL sb2_event got kind=%0d ch=%0d expected kind=%0d ch=%0d t=%0t",
                                     s, ch2, e2.kind, e2.ch, $time);
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input int rhythm_from);
        for (int c = 0; c < 18; c++) begin
            if (c % 2 == 1) exp_q.push_back('{kind: ((c >> 1) >= rhythm_from) ? 1 : 0, ch: c >> 1});
            if (c == 17)    exp_q.push_back('{kind: 2, ch: -1});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rhy_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            phim_n = r[0];
            @(negedge clk);
            if (r > 0) begin
                total++;
                if ({pcen_n, ncen_n, dac, mo, ro, frm} !== 6'b110000) begin
                    bad++;
                    $display("FAIL reset_enables got %b expected 110000", {pcen_n, ncen_n, dac, mo, ro, frm});
                end
                total++;
                if ({cyc, c00, clast, rctl} !== {5'd0, 3'b100}) begin
                    bad++;
                    $display("FAIL reset_cycle got cyc=%0d c00=%b last=%b rctl=%b expected 0 1 0 0", cyc, c00, clast, rctl);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        int ec;
        rst = 1'b1; phim_n = 1'b0; rhy_en = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        push_frame(99); push_frame(99);
        mon1 = 1'b1;
        for (int k = 0; k < 148; k++) begin
            phim_n = 1'b0;
            @(negedge clk);
            ec = ((k + 1) / 4) % 18;
            total++;
            if ({pcen_n, ncen_n, dac} !== {(k % 4 != 2), (k % 4 != 0), (k % 4 == 0)}) begin
                bad++;
                $display("FAIL basic_enables k=%0d got %b", k, {pcen_n, ncen_n, dac});
            end
            total++;
            if ({cyc, ch, mnc, c00, clast} !== {5'(ec), 4'(ec >> 1), ec[0], (ec == 0), (ec == 17)}) begin
                bad++;
                $display("FAIL basic_cycle k=%0d got cyc=%0d ch=%0d mnc=%b c00=%b last=%b expected cyc=%0d",
                         k, cyc, ch, mnc, c00, clast, ec);
            end
            total++;
            if (frm !== ((k % 4 == 2) && (ec == 17))) begin
                bad++;
                $display("FAIL basic_frame k=%0d got %b", k, frm);
            end
            @(posedge clk); #1;
        end
        mon1 = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_sb_left got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_hold();
        int ec;
        rst = 1'b1; phim_n = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        push_frame(99);
        mon1 = 1'b1;
        for (int k = 0; k < 148; k++) begin
            phim_n = k[0];
            @(negedge clk);
            ec = ((k + 3) / 8) % 18;
            total++;
            if ({pcen_n, ncen_n} !== {(k % 8 != 4), (k % 8 != 0)}) begin
                bad++;
                $display("FAIL hold_enables k=%0d got %b", k, {pcen_n, ncen_n});
            end
            total++;
            if (cyc !== 5'(ec) || frm !== ((k % 8 == 4) && (ec == 17))) begin
                bad++;
                $display("FAIL hold_cycle k=%0d got cyc=%0d frm=%b expected cyc=%0d", k, cyc, frm, ec);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 24; k++) begin
            phim_n = 1'b1;
            @(negedge clk);
            total++;
            if ({pcen_n, ncen_n, dac, cyc} !== {3'b110, 5'd0}) begin
                bad++;
                $display("FAIL hold_static k=%0d got en=%b cyc=%0d expected 110 0", k, {pcen_n, ncen_n, dac}, cyc);
            end
            @(posedge clk); #1;
        end
        phim_n = 1'b0;
        @(negedge clk);
        total++;
        if (pcen_n !== 1'b0) begin
            bad++;
            $display("FAIL hold_resume_pcen got %b expected 0", pcen_n);
        end
        @(posedge clk); #1;
        phim_n = 1'b1;
        @(negedge clk);
        mon1 = 1'b0;
        total++;
        if (cyc !== 5'd1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL hold_resume_cycle got cyc=%0d pending=%0d expected 1 0", cyc, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rhythm();
        int ec, f;
        int mo_cnt[3];
        int ro_cnt[3];
        mo_cnt = '{0, 0, 0}; ro_cnt = '{0, 0, 0};
        rst = 1'b1; phim_n = 1'b0; rhy_en = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        push_frame(99); push_frame(6);
        mon1 = 1'b1;
        for (int k = 0; k < 148; k++) begin
            phim_n = 1'b0;
            if (k >= 19) rhy_en = 1'b1;
            @(negedge clk);
            ec = ((k + 1) / 4) % 18;
            f  = ((k + 1) / 4) / 18;
            if (mo) mo_cnt[f]++;
            if (ro) ro_cnt[f]++;
            total++;
            if (cyc !== 5'(ec) || rctl !== ((f >= 1) && ((ec >> 1) >= 6))) begin
                bad++;
                $display("FAIL rhythm_ctrl k=%0d got cyc=%0d rctl=%b expected cyc=%0d", k, cyc, rctl, ec);
            end
            total++;
            if (mo && ro) begin
                bad++;
                $display("FAIL rhythm_both k=%0d got mo=1 ro=1 expected at most one", k);
            end
            @(posedge clk); #1;
        end
        total++;
        if (mo_cnt[0] != 9 || ro_cnt[0] != 0) begin
            bad++;
            $display("FAIL rhythm_frame0 got mo=%0d ro=%0d expected 9 0", mo_cnt[0], ro_cnt[0]);
        end
        total++;
        if (mo_cnt[1] != 6 || ro_cnt[1] != 3) begin
            bad++;
            $display("FAIL rhythm_frame1 got mo=%0d ro=%0d expected 6 3", mo_cnt[1], ro_cnt[1]);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rhythm_sb_left got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int  w;
        bit  found;
        found = 1'b0;
        for (int c = 1; c < 11; c += 2) exp_q.push_back('{kind: 0, ch: c >> 1});
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (cyc == 5'd11) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!found || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_reach got found=%b pending=%0d expected 1 0", found, exp_q.size());
        end
        #1; rst = 1'b1;
        for (int r = 0; r < 6; r++) begin
            phim_n = 1'b0;
            @(negedge clk);
            total++;
            if ({pcen_n, ncen_n, dac, mo, ro, frm, cyc} !== {6'b110000, 5'd0}) begin
                bad++;
                $display("FAIL rstmid_inactive r=%0d got %b cyc=%0d expected 110000 0",
                         r, {pcen_n, ncen_n, dac, mo, ro, frm}, cyc);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        push_frame(99);
        for (int k = 0; k < 72; k++) begin
            phim_n = 1'b0;
            @(negedge clk);
            if (k == 0) begin
                total++;
                if ({cyc, c00, ncen_n} !== {5'd0, 2'b10}) begin
                    bad++;
                    $display("FAIL rstmid_release got cyc=%0d c00=%b ncen_n=%b expected 0 1 0", cyc, c00, ncen_n);
                end
            end
            total++;
            if (rctl !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_rhythm k=%0d got rctl=%b expected 0", k, rctl);
            end
            @(posedge clk); #1;
        end
        mon1 = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_sb_left got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_small();
        int ec;
        rst2 = 1'b1; phim2_n = 1'b0; rhy2 = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst2 = 1'b0;
        exp2_q.delete();
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 12; c++) begin
                if (c % 2 == 1) exp2_q.push_back('{kind: 0, ch: c >> 1});
                if (c == 11)    exp2_q.push_back('{kind: 2, ch: -1});
            end
        mon2 = 1'b1;
        for (int k = 0; k < 196; k++) begin
            phim2_n = 1'b0;
            @(negedge clk);
            ec = ((k + 3) / 8) % 12;
            total++;
            if ({pcen2_n, ncen2_n, dac2} !== {(k % 8 != 4), (k % 8 != 0), (k % 8 == 0)}) begin
                bad++;
                $display("FAIL small_enables k=%0d got %b", k, {pcen2_n, ncen2_n, dac2});
            end
            total++;
            if ({cyc2, ch2, clast2, frm2} !== {4'(ec), 3'(ec >> 1), (ec == 11), ((k % 8 == 4) && (ec == 11))}) begin
                bad++;
                $display("FAIL small_cycle k=%0d got cyc=%0d ch=%0d last=%b frm=%b expected cyc=%0d",
                         k, cyc2, ch2, clast2, frm2, ec);
            end
            total++;
            if (rctl2 !== 1'b0 || ro2 !== 1'b0) begin
                bad++;
                $display("FAIL small_norhythm k=%0d got rctl=%b ro=%b expected 0 0", k, rctl2, ro2);
            end
            @(posedge clk); #1;
        end
        mon2 = 1'b0;
        total++;
        if (exp2_q.size() != 0) begin
            bad++;
            $display("FAIL small_sb_left got %0d pending expected 0", exp2_q.size());
        end
    endtask

    initial begin
        total = 0; bad = 0; mon1 = 1'b0; mon2 = 1'b0;
        rst = 1'b1; phim_n = 1'b1; rhy_en = 1'b0;
        rst2 = 1'b1; phim2_n = 1'b1; rhy2 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_hold();
        test_rhythm();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
